// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, one-word fetch handshake with instruction memory,
// and field decode of the fetched instruction. OP_JMP is 4'hE and OP_BR is 4'hF.
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   NIB_SIZE  = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 do_fetch_i,
    input  logic                 do_next_i,
    input  logic                 br_cond_i,
    input  logic [WORD_SIZE-1:0] jmp_target_i,
    output logic [WORD_SIZE-1:0] imem_addr_o,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    input  logic [WORD_SIZE-1:0] imem_data_i,
    output logic [WORD_SIZE-1:0] pc_o,
    output logic [NIB_SIZE-1:0]  opcode_o,
    output logic [NIB_SIZE-1:0]  rd_o,
    output logic [NIB_SIZE-1:0]  ra_o,
    output logic [NIB_SIZE-1:0]  rb_o,
    output logic [7:0]           imm8_o,
    output logic                 isaluop_o,
    output logic                 fetch_busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [NIB_SIZE-1:0] OP_JMP = NIB_SIZE'(14);
    localparam logic [NIB_SIZE-1:0] OP_BR  = NIB_SIZE'(15);

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] imm_ext;
    logic [WORD_SIZE-1:0] pc_next;

    assign opcode_o  = ir_q[WORD_SIZE-1 -: NIB_SIZE];
    assign rd_o      = ir_q[3*NIB_SIZE-1 -: NIB_SIZE];
    assign ra_o      = ir_q[2*NIB_SIZE-1 -: NIB_SIZE];
    assign rb_o      = ir_q[NIB_SIZE-1:0];
    assign imm8_o    = ir_q[7:0];
    assign isaluop_o = ~opcode_o[NIB_SIZE-1];

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign imem_req_o   = (state_q == ST_REQ);
    assign fetch_busy_o = (state_q == ST_REQ);

    // Branch offset is a signed 8-bit displacement; wraparound falls out of fixed-width adds.
    assign imm_ext = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        if (opcode_o == OP_JMP) begin
            pc_next = jmp_target_i;
        end else if ((opcode_o == OP_BR) && br_cond_i) begin
            pc_next = pc_q + imm_ext;
        end else begin
            pc_next = pc_q + WORD_SIZE'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle do_next lands before the request, so the fetch uses the new pc.
                if (do_next_i) begin
                    pc_d = pc_next;
                end
                if (do_fetch_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (do_next_i) begin
                    pc_d = pc_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        do_fetch_i, do_next_i, br_cond_i;
    logic [15:0] jmp_target_i;
    logic [15:0] imem_addr_o;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] pc_o;
    logic [3:0]  opcode_o, rd_o, ra_o, rb_o;
    logic [7:0]  imm8_o;
    logic        isaluop_o, fetch_busy_o;

    always #5 clk = ~clk;

    fetch_unit #(.WORD_SIZE(16), .NIB_SIZE(4), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .do_fetch_i   (do_fetch_i),
        .do_next_i    (do_next_i),
        .br_cond_i    (br_cond_i),
        .jmp_target_i (jmp_target_i),
        .imem_addr_o  (imem_addr_o),
        .imem_req_o   (imem_req_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .opcode_o     (opcode_o),
        .rd_o         (rd_o),
        .ra_o         (ra_o),
        .rb_o         (rb_o),
        .imm8_o       (imm8_o),
        .isaluop_o    (isaluop_o),
        .fetch_busy_o (fetch_busy_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: an outstanding-request flag, a one-cycle "just fetched" flag, pc and ir.
    bit          m_out;
    bit          m_done;
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [15:0] ir,
                                             input logic bc, input logic [15:0] jt);
        int op;
        int imm;
        op  = int'(ir) / 4096;
        imm = int'(ir) % 256;
        if (imm >= 128) imm = imm - 256;
        if (op == 14) return jt;
        if (op == 15 && bc) return 16'((int'(pc) + imm + 65536) % 65536);
        return 16'((int'(pc) + 1) % 65536);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_out  = 1'b0;
            m_done = 1'b0;
            m_pc   = 16'h0000;
            m_ir   = 16'h0000;
        end else if (m_out) begin
            if (imem_ack_i) begin
                m_ir   = imem_data_i;
                m_out  = 1'b0;
                m_done = 1'b1;
                $display("fetch pc=%04h ir=%04h", m_pc, m_ir);
            end
        end else begin
            if (do_next_i) m_pc = ref_next(m_pc, m_ir, br_cond_i, jmp_target_i);
            if (!m_done && do_fetch_i) m_out = 1'b1;
            m_done = 1'b0;
        end
    endtask

    task automatic compare_all();
        int iri;
        iri = int'(m_ir);
        check_val("imem_req",   32'(imem_req_o),   32'(m_out));
        check_val("fetch_busy", 32'(fetch_busy_o), 32'(m_out));
        check_val("pc",         32'(pc_o),         32'(m_pc));
        check_val("imem_addr",  32'(imem_addr_o),  32'(m_pc));
        check_val("opcode",     32'(opcode_o),     32'(iri / 4096));
        check_val("rd",         32'(rd_o),         32'((iri / 256) % 16));
        check_val("ra",         32'(ra_o),         32'((iri / 16) % 16));
        check_val("rb",         32'(rb_o),         32'(iri % 16));
        check_val("imm8",       32'(imm8_o),       32'(iri % 256));
        check_val("isaluop",    32'(isaluop_o),    32'((iri / 4096) < 8));
    endtask

    task automatic tick(input bit f, input bit n, input bit a, input logic [15:0] d);
        do_fetch_i  = f;
        do_next_i   = n;
        imem_ack_i  = a;
        imem_data_i = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        do_fetch_i = 1'b0;
        do_next_i  = 1'b0;
        imem_ack_i = 1'b0;
    endtask

    task automatic fetch_word(input logic [15:0] d);
        tick(1, 0, 0, 16'h0);
        tick(0, 0, 1, d);
        tick(0, 0, 0, 16'h0);
    endtask

    logic [15:0] pc_save;

    initial begin
        rst_n = 1'b0; do_fetch_i = 0; do_next_i = 0; br_cond_i = 0;
        jmp_target_i = 16'h0; imem_ack_i = 0; imem_data_i = 16'h0;
        m_out = 0; m_done = 0; m_pc = 16'h0; m_ir = 16'h0;

        tick(0, 0, 0, 16'h0);
        tick(1, 1, 1, 16'hFFFF);
        rst_n = 1'b1;
        check_val("rst_pc",  32'(pc_o), 32'h0000);
        check_val("rst_req", 32'(imem_req_o), 32'h0);

        // Basic fetch with one-cycle ack
        tick(1, 0, 0, 16'h0);
        check_val("lat_busy1", 32'(fetch_busy_o), 32'h1);
        tick(0, 0, 1, 16'h1234);
        check_val("dec_op",  32'(opcode_o), 32'h1);
        check_val("dec_rd",  32'(rd_o), 32'h2);
        check_val("dec_ra",  32'(ra_o), 32'h3);
        check_val("dec_rb",  32'(rb_o), 32'h4);
        check_val("dec_alu", 32'(isaluop_o), 32'h1);
        check_val("lat_busy2", 32'(fetch_busy_o), 32'h0);
        tick(0, 0, 0, 16'h0);

        // Stalled ack with a redundant do_fetch mid-wait
        pc_save = pc_o;
        tick(1, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            tick(i == 2, 0, 0, 16'h0);
            check_val("stall_req",  32'(imem_req_o), 32'h1);
            check_val("stall_addr", 32'(imem_addr_o), 32'(pc_save));
        end
        tick(0, 0, 1, 16'h0000);
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        check_val("no_extra_req", 32'(imem_req_o), 32'h0);
        tick(0, 0, 1, 16'hFFFF);
        check_val("stray_ack_ir", 32'(opcode_o), 32'h0);

        // Branches from 0x0010
        fetch_word(16'hE000);
        jmp_target_i = 16'h0010;
        tick(0, 1, 0, 16'h0);
        check_val("jmp_0010", 32'(pc_o), 32'h0010);
        fetch_word(16'hF0FC);
        br_cond_i = 1'b1;
        tick(0, 1, 0, 16'h0);
        check_val("br_taken", 32'(pc_o), 32'h000C);
        fetch_word(16'hE000);
        tick(0, 1, 0, 16'h0);
        fetch_word(16'hF0FC);
        br_cond_i = 1'b0;
        tick(0, 1, 0, 16'h0);
        check_val("br_not_taken", 32'(pc_o), 32'h0011);

        // Wraparound in both directions, then absolute jump
        fetch_word(16'hE000);
        jmp_target_i = 16'hFFFF;
        tick(0, 1, 0, 16'h0);
        fetch_word(16'h1000);
        tick(0, 1, 0, 16'h0);
        check_val("wrap_up", 32'(pc_o), 32'h0000);
        fetch_word(16'hF0FC);
        br_cond_i = 1'b1;
        tick(0, 1, 0, 16'h0);
        check_val("wrap_down", 32'(pc_o), 32'hFFFC);
        fetch_word(16'hE000);
        jmp_target_i = 16'h0400;
        tick(0, 1, 0, 16'h0);
        check_val("jmp_0400", 32'(pc_o), 32'h0400);

        // do_next during REQ is ignored; do_fetch+do_next together uses the new pc
        tick(1, 0, 0, 16'h0);
        tick(0, 1, 0, 16'h0);
        check_val("next_in_req", 32'(pc_o), 32'h0400);
        tick(0, 0, 1, 16'h2000);
        tick(0, 0, 0, 16'h0);
        tick(1, 1, 0, 16'h0);
        check_val("fetch_next_addr", 32'(imem_addr_o), 32'h0401);
        check_val("fetch_next_req",  32'(imem_req_o), 32'h1);
        tick(0, 0, 1, 16'h3456);
        tick(0, 0, 0, 16'h0);

        // Reset during REQ aborts; a late ack is ignored
        tick(1, 0, 0, 16'h0);
        rst_n = 1'b0;
        tick(0, 0, 0, 16'h0);
        rst_n = 1'b1;
        check_val("abort_req", 32'(imem_req_o), 32'h0);
        check_val("abort_pc",  32'(pc_o), 32'h0000);
        tick(0, 0, 1, 16'hABCD);
        check_val("abort_ir", 32'({opcode_o, rd_o, imm8_o}), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            br_cond_i    = 1'($urandom_range(0, 1));
            jmp_target_i = 16'($urandom);
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), 16'($urandom));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001 Parameter WORD_SIZE, default 16, width of PC, instruction and data words.
- REQ-002 Parameter NIB_SIZE, default 4, width of opcode and register-index fields.
- REQ-003 Parameter RESET_PC, default 16'h0000, PC value after reset.
- REQ-004 clk  input  1  single clock; all state updates on rising edge.
- REQ-005 rst_n  input  1  reset, synchronous, active-low.
- REQ-006 do_fetch  input  1  one-cycle pulse from control: start instruction fetch.
- REQ-007 do_next  input  1  one-cycle pulse from control: advance PC.
- REQ-008 br_cond  input  1  branch condition flag, sampled only on do_next.
- REQ-009 jmp_target  input  WORD_SIZE  register-supplied absolute jump address.
- REQ-010 imem_addr  output  WORD_SIZE  instruction memory address (equals pc).
- REQ-011 imem_req  output  1  instruction read request, held until ack.
- REQ-012 imem_ack  input  1  memory data valid this cycle.
- REQ-013 imem_data  input  WORD_SIZE  instruction word from memory.
- REQ-014 pc  output  WORD_SIZE  current program counter.
- REQ-015 opcode  output  NIB_SIZE  ir[15:12].
- REQ-016 rd, ra, rb  output  NIB_SIZE each  ir[11:8], ir[7:4], ir[3:0].
- REQ-017 imm8  output  8  ir[7:0].
- REQ-018 isaluop  output  1  1 when opcode is 0x0-0x7 (ALU ops); OP_LOAD..OP_BR occupy 0x8-0xF.
- REQ-019 fetch_busy  output  1  fetch in progress; control stalls while high.

Function
- REQ-020 FSM states: IDLE, REQ, DONE; IDLE is the only state accepting do_fetch.
- REQ-021 IDLE + do_fetch -> REQ next cycle; imem_req=1, fetch_busy=1 from that cycle.
- REQ-022 REQ: imem_req held high, imem_addr stable at pc, until imem_ack=1.
- REQ-023 REQ + imem_ack -> ir <= imem_data on that edge; next state DONE; imem_req low from next cycle.
- REQ-024 Minimum fetch latency: do_fetch cycle N -> ir valid and fetch_busy low at cycle N+2 with ack at N+1.
- REQ-025 DONE -> IDLE unconditionally next cycle; fetch_busy=0 in DONE and IDLE.
- REQ-026 do_fetch while in REQ or DONE: ignored, no second request, no error.
- REQ-027 imem_ack while not in REQ: ignored; ir unchanged.
- REQ-028 Decoded outputs (opcode, rd, ra, rb, imm8, isaluop) combinational from ir; stable between fetches.
- REQ-029 do_next in IDLE or DONE updates pc on that edge: OP_JMP -> jmp_target; OP_BR and br_cond=1 -> pc + sign_extend(imm8); otherwise pc + 1.
- REQ-030 PC arithmetic modulo 2^WORD_SIZE: 16'hFFFF + 1 -> 16'h0000; backward branch below 0 wraps.
- REQ-031 do_next while in REQ: ignored; pc unchanged (pc never changes during an outstanding request).
- REQ-032 do_fetch and do_next same cycle in IDLE: pc updates, fetch starts next cycle using the updated pc.

Reset
- REQ-033 rst_n=0 at a clock edge: state IDLE, pc=RESET_PC, ir=0, imem_req=0, fetch_busy=0.
- REQ-034 Reset mid-fetch (state REQ) aborts the request: imem_req low next cycle, late ack ignored.
- REQ-035 Reset dominates all other inputs in the same cycle.

Verification
- REQ-036 Reset, do_fetch, ack 1 cycle later with 16'h1234 -> opcode=1, rd=2, ra=3, rb=4, isaluop=1, fetch_busy low 2 cycles after do_fetch.
- REQ-037 do_fetch, ack withheld 5 cycles -> imem_req and imem_addr stable all 5 cycles; second do_fetch mid-wait produces no extra request.
- REQ-038 pc=16'h0010, ir opcode OP_BR, imm8=8'hFC, br_cond=1, do_next -> pc=16'h000C; br_cond=0 -> pc=16'h0011.
- REQ-039 pc=16'hFFFF, non-branch ir, do_next -> pc=16'h0000; OP_JMP, jmp_target=16'h0400 -> pc=16'h0400.
- REQ-040 Assert rst_n=0 during REQ, then ack -> pc=RESET_PC, ir=0, imem_req=0, ack ignored.
- REQ-041 do_next during REQ -> pc unchanged; do_fetch+do_next same cycle in IDLE -> imem_addr equals updated pc.
